// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - state encodings and defaults shared by the boot loader files
package imem_boot_loader_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CNT_HI = 3'd1;
  localparam logic [2:0] S_CNT_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

  // Busy covers every state from the count bytes through the checksum byte.
  function automatic logic is_busy_state(input logic [2:0] s);
    return (s >= S_CNT_HI) && (s <= S_CHECK);
  endfunction

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// rtl/imem_boot_loader_word_assembler.sv - MSB-first byte to 32-bit word shifter
module imem_boot_loader_word_assembler (
  input  logic        Clock,
  input  logic        NReset,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  input  logic        i_clear,
  output logic [31:0] o_word,
  output logic        o_full
);

  logic [23:0] r_shift;
  logic [1:0]  r_byte_cnt;

  // o_word is the word as it stands once the presented byte is shifted in.
  assign o_word = {r_shift, i_byte};
  assign o_full = (r_byte_cnt == 2'd3);

  always_ff @(posedge Clock or negedge NReset) begin
    if (!NReset) begin
      r_shift    <= 24'h0;
      r_byte_cnt <= 2'd0;
    end else if (i_clear) begin
      r_shift    <= 24'h0;
      r_byte_cnt <= 2'd0;
    end else if (i_shift) begin
      r_shift    <= {r_shift[15:0], i_byte};
      r_byte_cnt <= r_byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - framed byte stream loader for instruction memory, gates CPU reset
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 256,
  parameter logic [31:0] BASE_ADDRESS = 32'h0,
  parameter logic [7:0]  MAGIC        = DEFAULT_MAGIC
) (
  input  logic        Clock,
  input  logic        NReset,
  input  logic        ByteValid,
  input  logic [7:0]  ByteData,
  output logic        ByteReady,
  output logic        MemWriteEnable,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        CpuNReset,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS + 1);

  logic [2:0]       r_state;
  logic [15:0]      r_count;
  logic [IDX_W-1:0] r_index;
  logic [7:0]       r_xor;
  logic             r_ready, r_we, r_cpu_nrst, r_busy, r_done, r_err;
  logic [31:0]      r_addr, r_wdata;

  logic [2:0]       w_next;
  logic             w_acc, w_magic_acc, w_full, w_cnt_over, w_idx_last;
  logic [15:0]      w_cnt;
  logic [IDX_W-1:0] w_idx_next;
  logic [31:0]      w_word;

  assign w_acc       = ByteValid && r_ready;
  assign w_magic_acc = w_acc && (ByteData == MAGIC) &&
                       ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
  assign w_cnt       = {r_count[15:8], ByteData};
  assign w_cnt_over  = 32'(w_cnt) > 32'(DEPTH_WORDS);
  assign w_idx_next  = r_index + IDX_W'(1);
  assign w_idx_last  = (16'(w_idx_next) == r_count);

  imem_boot_loader_word_assembler u_asm (
    .Clock  (Clock),
    .NReset (NReset),
    .i_shift(w_acc && (r_state == S_DATA)),
    .i_byte (ByteData),
    .i_clear(w_magic_acc),
    .o_word (w_word),
    .o_full (w_full)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CNT_HI: if (w_acc) w_next = S_CNT_LO;
      S_CNT_LO: begin
        if (w_acc) begin
          if (w_cnt_over)        w_next = S_ERROR;
          else if (w_cnt == '0)  w_next = S_CHECK;
          else                   w_next = S_DATA;
        end
      end
      S_DATA:   if (w_acc && w_full) w_next = S_WRITE;
      S_WRITE:  w_next = w_idx_last ? S_CHECK : S_DATA;
      S_CHECK:  if (w_acc) w_next = (ByteData == r_xor) ? S_DONE : S_ERROR;
      default:  if (w_magic_acc) w_next = S_CNT_HI;
    endcase
  end

  always_ff @(posedge Clock or negedge NReset) begin
    if (!NReset) begin
      r_state    <= S_IDLE;
      r_count    <= 16'h0;
      r_index    <= '0;
      r_xor      <= 8'h0;
      r_ready    <= 1'b0;
      r_we       <= 1'b0;
      r_cpu_nrst <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
    end else begin
      // Status outputs are registered from the next state so they line up with it.
      r_state    <= w_next;
      r_ready    <= (w_next != S_WRITE);
      r_we       <= (w_next == S_WRITE);
      r_cpu_nrst <= (w_next == S_DONE);
      r_done     <= (w_next == S_DONE);
      r_err      <= (w_next == S_ERROR);
      r_busy     <= is_busy_state(w_next);

      if (w_magic_acc) begin
        r_xor   <= 8'h0;
        r_index <= '0;
      end
      if (w_acc) begin
        case (r_state)
          S_CNT_HI: begin
            r_count[15:8] <= ByteData;
            r_xor         <= r_xor ^ ByteData;
          end
          S_CNT_LO: begin
            r_count[7:0] <= ByteData;
            r_xor        <= r_xor ^ ByteData;
          end
          S_DATA: begin
            r_xor <= r_xor ^ ByteData;
            if (w_full) begin
              r_wdata <= w_word;
              r_addr  <= BASE_ADDRESS + 32'({r_index, 2'b00});
            end
          end
          default: ;
        endcase
      end
      if (r_state == S_WRITE) r_index <= w_idx_next;
    end
  end

  assign ByteReady      = r_ready;
  assign MemWriteEnable = r_we;
  assign MemAddress     = r_addr;
  assign MemWriteData   = r_wdata;
  assign CpuNReset      = r_cpu_nrst;
  assign Busy           = r_busy;
  assign Done           = r_done;
  assign Error          = r_err;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

  logic        Clock = 1'b0;
  logic        NReset = 1'b0;
  logic        ByteValid = 1'b0;
  logic [7:0]  ByteData = 8'h00;
  logic        ByteReady, MemWriteEnable, CpuNReset, Busy, Done, Error;
  logic [31:0] MemAddress, MemWriteData;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] wr_addr [0:7];
  logic [31:0] wr_data [0:7];
  int          n_wr = 0;
  logic [7:0]  q [$];

  imem_boot_loader dut (
    .Clock         (Clock),
    .NReset        (NReset),
    .ByteValid     (ByteValid),
    .ByteData      (ByteData),
    .ByteReady     (ByteReady),
    .MemWriteEnable(MemWriteEnable),
    .MemAddress    (MemAddress),
    .MemWriteData  (MemWriteData),
    .CpuNReset     (CpuNReset),
    .Busy          (Busy),
    .Done          (Done),
    .Error         (Error)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (MemWriteEnable) begin
      if (n_wr < 8) begin
        wr_addr[n_wr] = MemAddress;
        wr_data[n_wr] = MemWriteData;
      end
      n_wr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called and returns at posedge+1; byte is accepted at the first edge with ByteReady high.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int t = 0;
    int gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    ByteValid = 1'b0;
    repeat (gap) begin @(posedge Clock); #1; end
    ByteValid = 1'b1;
    ByteData  = b;
    while (!ByteReady && t < 50) begin @(posedge Clock); #1; t++; end
    check("byte_accept", {31'b0, ByteReady}, 32'd1);
    @(posedge Clock); #1;
    ByteValid = 1'b0;
  endtask

  task automatic send_q(input int gap_max);
    foreach (q[i]) send_byte(q[i], gap_max);
  endtask

  task automatic check_good_writes(input string pfx);
    check({pfx, "_nwr"},   n_wr, 2);
    check({pfx, "_addr0"}, wr_addr[0], 32'h0);
    check({pfx, "_data0"}, wr_data[0], 32'h3C010001);
    check({pfx, "_addr1"}, wr_addr[1], 32'h4);
    check({pfx, "_data1"}, wr_data[1], 32'h20220005);
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_ready"}, {31'b0, ByteReady}, 32'd0);
    check({pfx, "_we"},    {31'b0, MemWriteEnable}, 32'd0);
    check({pfx, "_addr"},  MemAddress, 32'd0);
    check({pfx, "_wdata"}, MemWriteData, 32'd0);
    check({pfx, "_cpu"},   {31'b0, CpuNReset}, 32'd0);
    check({pfx, "_stat"},  {29'b0, Busy, Done, Error}, 32'd0);
  endtask

  initial begin
    // 1. reset
    repeat (3) @(posedge Clock);
    #1;
    check_zero_outputs("rst");
    NReset = 1'b1;
    check("rel_ready_pre", {31'b0, ByteReady}, 32'd0);
    @(posedge Clock); #1;
    check("rel_ready", {31'b0, ByteReady}, 32'd1);
    check("rel_cpu", {31'b0, CpuNReset}, 32'd0);
    check("rel_stat", {29'b0, Busy, Done, Error}, 32'd0);

    // 2. good frame, with write latency probed after the 4th data byte
    n_wr = 0;
    q = '{8'hA5, 8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h01};
    send_q(0);
    check("lat_we", {31'b0, MemWriteEnable}, 32'd1);
    check("lat_ready", {31'b0, ByteReady}, 32'd0);
    check("lat_addr", MemAddress, 32'h0);
    check("lat_data", MemWriteData, 32'h3C010001);
    check("lat_busy", {31'b0, Busy}, 32'd1);
    q = '{8'h20, 8'h22, 8'h00, 8'h05, 8'h39};
    send_q(0);
    check("good_stat", {29'b0, Busy, Done, Error}, 32'b010);
    check("good_cpu", {31'b0, CpuNReset}, 32'd1);
    repeat (2) @(posedge Clock); #1;
    check_good_writes("good");

    // 3. bad checksum; MAGIC in DONE drops CpuNReset on the accepting edge
    n_wr = 0;
    send_byte(8'hA5, 0);
    check("redo_cpu", {31'b0, CpuNReset}, 32'd0);
    check("redo_stat", {29'b0, Busy, Done, Error}, 32'b100);
    q = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h01, 8'h20, 8'h22, 8'h00, 8'h05, 8'h38};
    send_q(0);
    check("bad_stat", {29'b0, Busy, Done, Error}, 32'b001);
    check("bad_cpu", {31'b0, CpuNReset}, 32'd0);
    check_good_writes("bad");

    // 4. count over depth, then recovery
    n_wr = 0;
    q = '{8'hA5, 8'h01, 8'h01};
    send_q(0);
    check("ovf_stat", {29'b0, Busy, Done, Error}, 32'b001);
    repeat (3) @(posedge Clock); #1;
    check("ovf_nwr", n_wr, 0);
    check("ovf_ready", {31'b0, ByteReady}, 32'd1);
    q = '{8'hA5, 8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h01, 8'h20, 8'h22, 8'h00, 8'h05, 8'h39};
    send_q(0);
    check("rec_stat", {29'b0, Busy, Done, Error}, 32'b010);
    check_good_writes("rec");

    // zero-length frame goes straight to the checksum byte
    n_wr = 0;
    q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_q(0);
    check("zero_stat", {29'b0, Busy, Done, Error}, 32'b010);
    check("zero_nwr", n_wr, 0);

    // 5. garbage before MAGIC, random valid gaps
    n_wr = 0;
    send_byte(8'hA5, 0);
    q = '{8'h00, 8'h00, 8'h00};
    send_q(0);
    q = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h01,
          8'h20, 8'h22, 8'h00, 8'h05, 8'h39};
    n_wr = 0;
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("pre_err", {31'b0, Error}, 32'd1);
    send_q(3);
    check("gap_stat", {29'b0, Busy, Done, Error}, 32'b010);
    check_good_writes("gap");

    // 6. reset mid-frame after 5 data bytes
    n_wr = 0;
    q = '{8'hA5, 8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h01, 8'h20};
    send_q(0);
    #2;
    NReset = 1'b0;
    #1;
    check_zero_outputs("mid");
    @(posedge Clock); #1;
    NReset = 1'b1;
    @(posedge Clock); #1;
    n_wr = 0;
    q = '{8'hA5, 8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h01, 8'h20, 8'h22, 8'h00, 8'h05, 8'h39};
    send_q(1);
    check("reload_stat", {29'b0, Busy, Done, Error}, 32'b010);
    check("reload_cpu", {31'b0, CpuNReset}, 32'd1);
    check_good_writes("reload");
    send_byte(8'hA5, 0);
    check("magic_cpu", {31'b0, CpuNReset}, 32'd0);
    check("magic_done", {31'b0, Done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
